call_stack: RTL and testbench
=============================

// Module: call_stack
// PURPOSE
// - Hardware return-address stack for CALL/RETURN instructions.
// - Sits directly upstream of pcounter: decode strobes push with the return address on CALL;
//   decode strobes pop on RETURN, and this block hands the saved address to pcounter for loading.
// - Circular, fixed depth, single clock domain.
// - Overflow overwrites the oldest entry; the block never stalls.
// PARAMETERS
// DEPTH  8   number of entries (power of two, >=2)
// AW     11  address width; matches the program counter width
// PORTS
// clk        in   1       system clock; all state updates on rising edge
// reset      in   1       asynchronous, active-low reset (0 = reset asserted)
// push       in   1       save pc_in this cycle (CALL); single-cycle strobe from decode
// pop        in   1       restore top entry this cycle (RETURN); single-cycle strobe
// pc_in      in   AW      return address to save (already PC+1)
// clr_flags  in   1       clears the sticky overflow/underflow flags
// ret_addr   out  AW      registered popped address, for the pcounter load
// ret_valid  out  1       one-cycle pulse: ret_addr is valid, pcounter loads it
// top        out  AW      combinational view of the current top entry (debug/monitor)
// count      out  log2(DEPTH)+1  number of valid entries, 0..DEPTH
// overflow   out  1       sticky: a push occurred while count==DEPTH
// underflow  out  1       sticky: a pop occurred while count==0
// BEHAVIOUR
// - Reset (reset==0, asynchronous):
//   - sp, count, ret_addr, ret_valid, overflow and underflow all go to 0.
//   - All DEPTH entries clear to 0.
//   - Outputs hold these values until the first rising edge after reset==1.
// - sp points to the next free slot; top = stack[(sp-1) mod DEPTH], so top is 0 after reset.
// - Push only, on the rising edge:
//   - stack[sp] <= pc_in; sp <= (sp+1) mod DEPTH.
//   - count <= min(count+1, DEPTH).
//   - If count==DEPTH beforehand, the oldest entry is overwritten and overflow <= 1.
// - Pop only, on the rising edge:
//   - ret_addr <= stack[(sp-1) mod DEPTH]; ret_valid <= 1 for exactly one cycle.
//   - sp <= (sp-1) mod DEPTH; count <= max(count-1, 0).
//   - If count==0 beforehand, the pointer still wraps, the stale entry is returned, and underflow <= 1.
// - Push and pop in the same cycle:
//   - If count>0: ret_addr <= old top; ret_valid <= 1; stack[(sp-1) mod DEPTH] <= pc_in.
//     sp and count are unchanged.
//   - If count==0: ret_addr <= stack[(sp-1) mod DEPTH]; ret_valid <= 1; underflow <= 1.
//     Then act as push: stack[sp] <= pc_in, sp+1, count <= 1.
// - Neither strobe: all state holds; ret_valid <= 0; ret_addr holds its last value.
// - Latency: ret_addr/ret_valid appear 1 clk after the pop edge. top and count reflect a push 1 clk after the push edge.
// - clr_flags:
//   - Clears overflow and underflow on the edge.
//   - If a new overflow/underflow event coincides with clr_flags, set wins.
//   - clr_flags never affects sp, count or the entries.
// - All pointer arithmetic is modulo DEPTH on log2(DEPTH) bits. count saturates and never wraps.
// - Reset asserted mid-operation (including during a ret_valid pulse) aborts immediately.
//   ret_valid drops to 0 asynchronously.
// TESTING
// - Reset released, no strobes -> count=0, top=0, ret_valid=0, flags=0 for 10 cycles.
// - Push 0x010, 0x020, 0x030, then pop x3:
//   - ret_addr = 0x030, 0x020, 0x010 on successive pops, each with a 1-cycle ret_valid.
//   - count ends at 0; no flags set.
// - Push 9 values 0x001..0x009 (DEPTH=8):
//   - overflow=1, count=8.
//   - 8 pops return 0x009..0x002.
//   - A 9th pop returns 0x009 (wrapped stale entry) and sets underflow=1.
// - count=2 (top 0x055), push 0x077 and pop in the same cycle:
//   - ret_addr=0x055, ret_valid=1; count stays 2; top=0x077.
// - Pop while empty together with clr_flags=1 -> underflow=1 (set wins); next cycle clr_flags=1 alone -> underflow=0.
// - Assert reset=0 on the same edge as a pop after 3 pushes:
//   - ret_valid=0, count=0, top=0 immediately.
//   - No ret_valid pulse after reset releases.

Source files
------------

// File: rtl/call_stack_if.sv
// Decode-side bundle for the return-address stack: CALL/RETURN strobes in, popped address and status out.
// master = decode/pcounter side, slave = call_stack.
interface call_stack_if #(
  parameter int DEPTH = 8,
  parameter int AW    = 11
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          push;
  logic          pop;
  logic [AW-1:0] pc_in;
  logic          clr_flags;
  logic [AW-1:0] ret_addr;
  logic          ret_valid;
  logic [AW-1:0] top;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  modport master (
    output push, pop, pc_in, clr_flags,
    input  ret_addr, ret_valid, top, count, overflow, underflow
  );

  modport slave (
    input  push, pop, pc_in, clr_flags,
    output ret_addr, ret_valid, top, count, overflow, underflow
  );
endinterface

// File: rtl/call_stack.sv
// Circular return-address stack; ret_addr/ret_valid 1 clk after pop, top/count 1 clk after push.
// Never stalls: overflow overwrites the oldest entry, underflow returns the stale wrapped entry.
module call_stack #(
  parameter int DEPTH = 8,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          reset,
  call_stack_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] stack [DEPTH];
  logic [PW-1:0] sp;
  logic [PW-1:0] sp_m1;
  logic [CW-1:0] cnt;
  logic [AW-1:0] ret_addr_q;
  logic          ret_valid_q;
  logic          ovf_q;
  logic          unf_q;

  logic [PW-1:0] nxt_sp;
  logic [CW-1:0] nxt_cnt;
  logic          wr_en;
  logic [PW-1:0] wr_idx;
  logic          do_ret;
  logic          ovf_set;
  logic          unf_set;

  assign sp_m1 = sp - PW'(1);

  always_comb begin
    nxt_sp  = sp;
    nxt_cnt = cnt;
    wr_en   = 1'b0;
    wr_idx  = sp;
    do_ret  = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case ({bus.push, bus.pop})
      2'b10: begin
        wr_en  = 1'b1;
        nxt_sp = sp + PW'(1);
        if (cnt == FULL) ovf_set = 1'b1;
        else             nxt_cnt = cnt + CW'(1);
      end
      2'b01: begin
        do_ret = 1'b1;
        nxt_sp = sp_m1;
        if (cnt == '0) unf_set = 1'b1;
        else           nxt_cnt = cnt - CW'(1);
      end
      2'b11: begin
        do_ret = 1'b1;
        wr_en  = 1'b1;
        if (cnt != '0) begin
          // Replace the top in place: the returned frame is swapped for the new one.
          wr_idx = sp_m1;
        end else begin
          unf_set = 1'b1;
          nxt_sp  = sp + PW'(1);
          nxt_cnt = CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
      sp          <= '0;
      cnt         <= '0;
      ret_addr_q  <= '0;
      ret_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      if (wr_en) stack[wr_idx] <= bus.pc_in;
      sp          <= nxt_sp;
      cnt         <= nxt_cnt;
      ret_valid_q <= do_ret;
      if (do_ret) ret_addr_q <= stack[sp_m1];
      // A new event in the same cycle as clr_flags keeps the flag set.
      ovf_q <= ovf_set | (ovf_q & ~bus.clr_flags);
      unf_q <= unf_set | (unf_q & ~bus.clr_flags);
    end
  end

  assign bus.ret_addr  = ret_addr_q;
  assign bus.ret_valid = ret_valid_q;
  assign bus.top       = stack[sp_m1];
  assign bus.count     = cnt;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_call_stack.sv
// Directed table-driven bench for call_stack (DEPTH=8, AW=11) plus reset corner sequences.
module tb_call_stack;
  localparam int DEPTH = 8;
  localparam int AW    = 11;

  typedef struct {
    logic          push;
    logic          pop;
    logic          clr;
    logic [AW-1:0] pc;
    logic          rv;
    logic [AW-1:0] ra;
    logic [3:0]    cnt;
    logic [AW-1:0] top;
    logic          ovf;
    logic          unf;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs[$];

  call_stack_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

  call_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic pu, input logic po, input logic cl, input logic [AW-1:0] pc,
                     input logic rv, input logic [AW-1:0] ra, input logic [3:0] cnt,
                     input logic [AW-1:0] top, input logic ovf, input logic unf);
    vec_t v;
    v.push = pu; v.pop = po; v.clr = cl; v.pc = pc;
    v.rv = rv; v.ra = ra; v.cnt = cnt; v.top = top; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic pu, input logic po, input logic cl, input logic [AW-1:0] pc);
    bus.push = pu; bus.pop = po; bus.clr_flags = cl; bus.pc_in = pc;
  endtask

  task automatic chk_all(input string tag, input logic rv, input logic [AW-1:0] ra,
                         input logic [3:0] cnt, input logic [AW-1:0] top,
                         input logic ovf, input logic unf);
    chk({tag, ".ret_valid"}, 32'(bus.ret_valid), 32'(rv));
    chk({tag, ".ret_addr"},  32'(bus.ret_addr),  32'(ra));
    chk({tag, ".count"},     32'(bus.count),     32'(cnt));
    chk({tag, ".top"},       32'(bus.top),       32'(top));
    chk({tag, ".overflow"},  32'(bus.overflow),  32'(ovf));
    chk({tag, ".underflow"}, 32'(bus.underflow), 32'(unf));
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // push 3 / pop 3
    add(1,0,0,11'h010, 0,11'h000,1,11'h010,0,0);
    add(1,0,0,11'h020, 0,11'h000,2,11'h020,0,0);
    add(1,0,0,11'h030, 0,11'h000,3,11'h030,0,0);
    add(0,1,0,11'h000, 1,11'h030,2,11'h020,0,0);
    add(0,1,0,11'h000, 1,11'h020,1,11'h010,0,0);
    add(0,1,0,11'h000, 1,11'h010,0,11'h000,0,0);
    add(0,0,0,11'h000, 0,11'h010,0,11'h000,0,0);
    // overflow: push 1..9, pop 9 times
    for (int k = 1; k <= 8; k++)
      add(1,0,0,AW'(k), 0,11'h010,4'(k),AW'(k),0,0);
    add(1,0,0,11'h009, 0,11'h010,8,11'h009,1,0);
    for (int j = 1; j <= 8; j++)
      add(0,1,0,11'h000, 1,AW'(10-j),4'(8-j),(j < 8) ? AW'(9-j) : 11'h009,1,0);
    add(0,1,0,11'h000, 1,11'h009,0,11'h008,1,1);
    add(0,0,1,11'h000, 0,11'h009,0,11'h008,0,0);
    // same-cycle push+pop with count=2
    add(1,0,0,11'h044, 0,11'h009,1,11'h044,0,0);
    add(1,0,0,11'h055, 0,11'h009,2,11'h055,0,0);
    add(1,1,0,11'h077, 1,11'h055,2,11'h077,0,0);
    add(0,0,0,11'h000, 0,11'h055,2,11'h077,0,0);
    // same-cycle push+pop while empty
    add(0,1,0,11'h000, 1,11'h077,1,11'h044,0,0);
    add(0,1,0,11'h000, 1,11'h044,0,11'h008,0,0);
    add(1,1,0,11'h0AA, 1,11'h008,1,11'h0AA,0,1);
    add(0,0,1,11'h000, 0,11'h008,1,11'h0AA,0,0);
    // empty pop coinciding with clr_flags: set wins
    add(0,1,0,11'h000, 1,11'h0AA,0,11'h008,0,0);
    add(0,1,1,11'h000, 1,11'h008,0,11'h007,0,1);
    add(0,0,1,11'h000, 0,11'h008,0,11'h007,0,0);

    drive(0,0,0,'0);
    reset = 1'b0;
    #1;
    chk_all("reset_async", 0, 11'h000, 0, 11'h000, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk_all($sformatf("idle%0d", i), 0, 11'h000, 0, 11'h000, 0, 0);
    end

    foreach (vecs[i]) begin
      drive(vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].pc);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].rv, vecs[i].ra, vecs[i].cnt,
              vecs[i].top, vecs[i].ovf, vecs[i].unf);
    end
    drive(0,0,0,'0);

    // Reset on the same edge as a pop after 3 pushes
    for (int k = 1; k <= 3; k++) begin
      drive(1,0,0,AW'(k * 16'h100));
      @(posedge clk);
      #1;
    end
    chk("pre_rst.count", 32'(bus.count), 32'd3);
    drive(0,1,0,'0);
    @(posedge clk);
    reset = 1'b0;
    #1;
    chk_all("rst_on_pop", 0, 11'h000, 0, 11'h000, 0, 0);
    drive(0,0,0,'0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst%0d.ret_valid", i), 32'(bus.ret_valid), 32'd0);
    end

    // Reset dropping in the middle of a ret_valid pulse
    drive(1,0,0,11'h123);
    @(posedge clk);
    #1;
    drive(0,1,0,'0);
    @(posedge clk);
    #1;
    drive(0,0,0,'0);
    chk("pulse.ret_valid", 32'(bus.ret_valid), 32'd1);
    chk("pulse.ret_addr",  32'(bus.ret_addr),  32'h123);
    #1;
    reset = 1'b0;
    #1;
    chk_all("rst_mid_pulse", 0, 11'h000, 0, 11'h000, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
